// File: rtl/irq_trap_ctrl_pkg.sv
// Shared definitions for the trap/interrupt controller: FSM encoding, cause layout
// and the lowest-index priority encoder also used by the CSR block.
package irq_trap_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_TAKE    = 2'd2,
    ST_HANDLER = 2'd3
  } trap_state_e;

  localparam int   PRIO_W         = 5;     // index width for up to 32 sources
  localparam int   EXC_CAUSE_BASE = 1;     // cause 0 is reserved
  localparam logic CAUSE_IRQ_BIT  = 1'b1;  // cause MSB value marking an interrupt

  // Index of the lowest set bit; 0 when nothing is set (callers qualify with |v).
  function automatic logic [PRIO_W-1:0] prio_lowest(input logic [31:0] v);
    prio_lowest = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) prio_lowest = PRIO_W'(i);
    end
  endfunction

endpackage

// File: rtl/irq_trap_ctrl_sync_edge.sv
// Single-channel synchroniser for an asynchronous interrupt line, with rising-edge
// detection on the synchronised level.
module irq_trap_ctrl_sync_edge #(
  parameter int SYNC_STG = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic lvl,
  output logic rise
);

  logic [SYNC_STG-1:0] sync_q;
  logic                lvl_p1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
      lvl_p1 <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], din};
      lvl_p1 <= sync_q[SYNC_STG-1];
    end
  end

  assign lvl  = sync_q[SYNC_STG-1];
  assign rise = lvl & ~lvl_p1;

endmodule

// File: rtl/irq_trap_ctrl.sv
// Trap/interrupt controller: maskable level/edge IRQ channels, synchronous exceptions
// with fixed priority, drain-before-entry for IRQs and handler tracking until mret.
module irq_trap_ctrl
  import irq_trap_ctrl_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter int               N_IRQ    = 8,
  parameter int               N_EXC    = 4,
  parameter logic [N_IRQ-1:0] IRQ_EDGE = '0,
  parameter int               SYNC_STG = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_EXC-1:0] exc_vec,
  input  logic [XLEN-1:0]  exc_pc,
  input  logic [XLEN-1:0]  irq_pc,
  input  logic             glb_ie,
  input  logic             pipe_drained,
  input  logic             mret,
  input  logic             csr_we,
  input  logic             csr_sel,
  input  logic [N_IRQ-1:0] csr_wdata,
  output logic [N_IRQ-1:0] enable_out,
  output logic [N_IRQ-1:0] pending_out,
  output logic             flush_trap,
  output logic [XLEN-1:0]  trap_cause,
  output logic [XLEN-1:0]  trap_epc,
  output logic             in_handler
);

  trap_state_e       state_q, state_nxt;
  logic [N_IRQ-1:0]  enable_q, pending_q, pending_nxt;
  logic [N_IRQ-1:0]  irq_lvl, irq_rise, clr_mask, elig;
  logic [PRIO_W-1:0] irq_idx_q, irq_idx, exc_idx;
  logic [XLEN-1:0]   cause_q, epc_q, cause_nxt, epc_nxt;
  logic              take_irq_q, take_irq_nxt;
  logic              load_trap, latch_idx, exc_any, sel_elig;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
    irq_trap_ctrl_sync_edge #(.SYNC_STG(SYNC_STG)) u_sync (
      .clk  (clk),
      .reset(reset),
      .din  (irq_in[g]),
      .lvl  (irq_lvl[g]),
      .rise (irq_rise[g])
    );
  end

  // Edge channels: set wins over W1C and over the clear on IRQ entry.
  always_comb begin
    clr_mask = '0;
    if (csr_we && csr_sel) clr_mask = csr_wdata;
    if (state_q == ST_TAKE && take_irq_q) clr_mask = clr_mask | (N_IRQ'(1) << irq_idx_q);
    pending_nxt = (IRQ_EDGE & (irq_rise | (pending_q & ~clr_mask))) | (~IRQ_EDGE & irq_lvl);
  end

  assign elig     = pending_q & enable_q & {N_IRQ{glb_ie}};
  assign irq_idx  = prio_lowest(32'(elig));
  assign exc_any  = |exc_vec;
  assign exc_idx  = prio_lowest(32'(exc_vec));
  assign sel_elig = |(elig & (N_IRQ'(1) << irq_idx_q));

  always_comb begin
    state_nxt    = state_q;
    load_trap    = 1'b0;
    latch_idx    = 1'b0;
    take_irq_nxt = 1'b0;
    cause_nxt    = XLEN'(exc_idx) + XLEN'(EXC_CAUSE_BASE);
    epc_nxt      = exc_pc;
    unique case (state_q)
      ST_IDLE: begin
        if (exc_any) begin
          state_nxt = ST_TAKE;
          load_trap = 1'b1;
        end else if (|elig) begin
          state_nxt = ST_DRAIN;
          latch_idx = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (exc_any) begin
          state_nxt = ST_TAKE;
          load_trap = 1'b1;
        end else if (!sel_elig) begin
          state_nxt = ST_IDLE;
        end else if (pipe_drained) begin
          state_nxt    = ST_TAKE;
          load_trap    = 1'b1;
          take_irq_nxt = 1'b1;
          cause_nxt    = {CAUSE_IRQ_BIT, (XLEN-1)'(irq_idx_q)};
          epc_nxt      = irq_pc;
        end
      end
      // The faulting instruction in flight is being flushed, so exc_vec is ignored here.
      ST_TAKE: state_nxt = ST_HANDLER;
      ST_HANDLER: begin
        if (exc_any) begin
          state_nxt = ST_TAKE;
          load_trap = 1'b1;
        end else if (mret) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      enable_q   <= '0;
      pending_q  <= '0;
      irq_idx_q  <= '0;
      take_irq_q <= 1'b0;
      cause_q    <= '0;
      epc_q      <= '0;
    end else begin
      state_q   <= state_nxt;
      pending_q <= pending_nxt;
      if (csr_we && !csr_sel) enable_q <= csr_wdata;
      if (latch_idx) irq_idx_q <= irq_idx;
      if (load_trap) begin
        take_irq_q <= take_irq_nxt;
        cause_q    <= cause_nxt;
        epc_q      <= epc_nxt;
      end
    end
  end

  assign enable_out  = enable_q;
  assign pending_out = pending_q;
  assign flush_trap  = (state_q == ST_TAKE);
  assign in_handler  = (state_q == ST_HANDLER);
  assign trap_cause  = cause_q;
  assign trap_epc    = epc_q;

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Directed bench for irq_trap_ctrl with channel 0 configured as an edge channel.
module tb_irq_trap_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_in;
  logic [3:0]  exc_vec;
  logic [31:0] exc_pc, irq_pc;
  logic        glb_ie, pipe_drained, mret, csr_we, csr_sel;
  logic [7:0]  csr_wdata;
  logic [7:0]  enable_out, pending_out;
  logic        flush_trap, in_handler;
  logic [31:0] trap_cause, trap_epc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  irq_trap_ctrl #(
    .XLEN(32), .N_IRQ(8), .N_EXC(4), .IRQ_EDGE(8'h01), .SYNC_STG(2)
  ) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .exc_vec(exc_vec), .exc_pc(exc_pc),
    .irq_pc(irq_pc), .glb_ie(glb_ie), .pipe_drained(pipe_drained), .mret(mret),
    .csr_we(csr_we), .csr_sel(csr_sel), .csr_wdata(csr_wdata), .enable_out(enable_out),
    .pending_out(pending_out), .flush_trap(flush_trap), .trap_cause(trap_cause),
    .trap_epc(trap_epc), .in_handler(in_handler)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0; irq_in = '0; exc_vec = '0; exc_pc = '0; irq_pc = '0;
    glb_ie = 1'b0; pipe_drained = 1'b0; mret = 1'b0;
    csr_we = 1'b0; csr_sel = 1'b0; csr_wdata = '0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic write_enable(input logic [7:0] v);
    csr_we = 1'b1; csr_sel = 1'b0; csr_wdata = v;
    tick();
    csr_we = 1'b0; csr_wdata = '0;
  endtask

  task automatic test_reset();
    logic [3:0] seen;
    apply_reset();
    reset = 1'b0; irq_in = 8'hFF;
    tick(); tick(); tick();
    total++;
    if ({enable_out, pending_out, flush_trap, in_handler, trap_cause, trap_epc} !== '0) begin
      bad++;
      $display("FAIL reset_outputs en=%h pend=%h flush=%b inh=%b cause=%h epc=%h want all 0",
               enable_out, pending_out, flush_trap, in_handler, trap_cause, trap_epc);
    end
    reset = 1'b1;
    tick(); tick();
    total++;
    if (pending_out !== 8'h00) begin
      bad++; $display("FAIL reset_pend_early got=%h want=00", pending_out);
    end
    tick();
    total++;
    if (pending_out !== 8'hFF) begin
      bad++; $display("FAIL reset_pend_latency got=%h want=ff", pending_out);
    end
    seen = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen[i] = flush_trap;
    end
    total++;
    if (seen !== 4'b0000) begin
      bad++; $display("FAIL reset_no_flush_masked flushes=%b want=0000", seen);
    end
  endtask

  task automatic test_level_irq();
    int nflush;
    logic [31:0] cap_cause, cap_epc;
    apply_reset();
    write_enable(8'h04);
    total++;
    if (enable_out !== 8'h04) begin
      bad++; $display("FAIL level_enable got=%h want=04", enable_out);
    end
    glb_ie = 1'b1; irq_in = 8'h04; irq_pc = 32'h0000_2000;
    nflush = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (flush_trap) nflush++;
    end
    pipe_drained = 1'b1;
    cap_cause = '0; cap_epc = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (flush_trap) begin
        nflush++; cap_cause = trap_cause; cap_epc = trap_epc;
      end
    end
    total++;
    if (nflush != 1) begin
      bad++; $display("FAIL level_flush_count got=%0d want=1", nflush);
    end
    total++;
    if (cap_cause !== 32'h8000_0002 || cap_epc !== 32'h0000_2000) begin
      bad++; $display("FAIL level_cause_epc cause=%h epc=%h want 80000002/00002000", cap_cause, cap_epc);
    end
    total++;
    if (in_handler !== 1'b1 || trap_cause !== 32'h8000_0002) begin
      bad++; $display("FAIL level_in_handler inh=%b cause=%h want 1/80000002", in_handler, trap_cause);
    end
  endtask

  task automatic test_priority();
    logic seen;
    apply_reset();
    write_enable(8'h01);
    irq_in = 8'h01; irq_pc = 32'h0000_5000;
    tick(); tick(); tick(); tick();
    total++;
    if (pending_out !== 8'h01) begin
      bad++; $display("FAIL prio_pend_setup got=%h want=01", pending_out);
    end
    glb_ie = 1'b1; exc_vec = 4'b1010; exc_pc = 32'h0000_3000;
    tick();
    exc_vec = '0;
    total++;
    if (flush_trap !== 1'b1 || trap_cause !== 32'd2 || trap_epc !== 32'h0000_3000) begin
      bad++; $display("FAIL prio_exc_first flush=%b cause=%h epc=%h want 1/00000002/00003000",
                      flush_trap, trap_cause, trap_epc);
    end
    tick();
    total++;
    if (flush_trap !== 1'b0 || in_handler !== 1'b1 || pending_out[0] !== 1'b1) begin
      bad++; $display("FAIL prio_irq_kept flush=%b inh=%b pend=%h want 0/1/pend0=1",
                      flush_trap, in_handler, pending_out);
    end
    pipe_drained = 1'b1;
    tick(); tick();
    mret = 1'b1;
    tick();
    mret = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      if (flush_trap) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b1 || trap_cause !== 32'h8000_0000 || trap_epc !== 32'h0000_5000) begin
      bad++; $display("FAIL prio_irq_after_mret seen=%b cause=%h epc=%h want 1/80000000/00005000",
                      seen, trap_cause, trap_epc);
    end
    tick();
    total++;
    if (pending_out[0] !== 1'b0) begin
      bad++; $display("FAIL prio_edge_cleared pend=%h want bit0=0", pending_out);
    end
  endtask

  task automatic test_edge();
    logic seen;
    apply_reset();
    irq_in = 8'h01; tick(); irq_in = 8'h00;
    tick(); tick();
    total++;
    if (pending_out !== 8'h01) begin
      bad++; $display("FAIL edge_latched got=%h want=01", pending_out);
    end
    tick(); tick();
    irq_in = 8'h01; tick(); irq_in = 8'h00;
    tick();
    csr_we = 1'b1; csr_sel = 1'b1; csr_wdata = 8'h01;
    tick();
    csr_we = 1'b0; csr_sel = 1'b0; csr_wdata = '0;
    total++;
    if (pending_out !== 8'h01) begin
      bad++; $display("FAIL edge_set_wins got=%h want=01", pending_out);
    end
    csr_we = 1'b1; csr_sel = 1'b1; csr_wdata = 8'h01;
    tick();
    csr_we = 1'b0; csr_sel = 1'b0; csr_wdata = '0;
    total++;
    if (pending_out !== 8'h00) begin
      bad++; $display("FAIL edge_w1c got=%h want=00", pending_out);
    end
    irq_in = 8'h01; tick(); irq_in = 8'h00; tick(); tick();
    write_enable(8'h01);
    glb_ie = 1'b1; pipe_drained = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      if (flush_trap) seen = 1'b1;
    end
    tick();
    total++;
    if (seen !== 1'b1 || trap_cause !== 32'h8000_0000 || pending_out !== 8'h00) begin
      bad++; $display("FAIL edge_take_clear seen=%b cause=%h pend=%h want 1/80000000/00",
                      seen, trap_cause, pending_out);
    end
  endtask

  task automatic test_nesting();
    int nflush;
    logic seen;
    apply_reset();
    write_enable(8'h02);
    glb_ie = 1'b1; pipe_drained = 1'b1;
    exc_vec = 4'b0100; exc_pc = 32'h0000_1100;
    tick();
    exc_vec = '0;
    total++;
    if (flush_trap !== 1'b1 || trap_cause !== 32'd3) begin
      bad++; $display("FAIL nest_exc_latency flush=%b cause=%h want 1/00000003", flush_trap, trap_cause);
    end
    tick();
    irq_in = 8'h02;
    nflush = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (flush_trap) nflush++;
    end
    total++;
    if (nflush != 0 || pending_out !== 8'h02 || in_handler !== 1'b1) begin
      bad++; $display("FAIL nest_irq_blocked flushes=%0d pend=%h inh=%b want 0/02/1",
                      nflush, pending_out, in_handler);
    end
    exc_vec = 4'b0001; exc_pc = 32'h0000_4000;
    tick();
    exc_vec = '0;
    total++;
    if (flush_trap !== 1'b1 || trap_cause !== 32'd1 || trap_epc !== 32'h0000_4000) begin
      bad++; $display("FAIL nest_exc_taken flush=%b cause=%h epc=%h want 1/00000001/00004000",
                      flush_trap, trap_cause, trap_epc);
    end
    tick();
    total++;
    if (in_handler !== 1'b1 || flush_trap !== 1'b0) begin
      bad++; $display("FAIL nest_back_in_handler inh=%b flush=%b want 1/0", in_handler, flush_trap);
    end
    mret = 1'b1;
    tick();
    mret = 1'b0;
    total++;
    if (in_handler !== 1'b0) begin
      bad++; $display("FAIL nest_mret inh=%b want 0", in_handler);
    end
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      if (flush_trap) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b1 || trap_cause !== 32'h8000_0001) begin
      bad++; $display("FAIL nest_irq1_taken seen=%b cause=%h want 1/80000001", seen, trap_cause);
    end
  endtask

  task automatic test_abort();
    int nflush;
    logic seen;
    apply_reset();
    write_enable(8'h08);
    glb_ie = 1'b1; irq_in = 8'h08; irq_pc = 32'h0000_6000;
    tick(); tick(); tick(); tick(); tick();
    glb_ie = 1'b0; pipe_drained = 1'b1;
    nflush = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (flush_trap) nflush++;
    end
    total++;
    if (nflush != 0 || in_handler !== 1'b0) begin
      bad++; $display("FAIL abort_no_trap flushes=%0d inh=%b want 0/0", nflush, in_handler);
    end
    glb_ie = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      if (flush_trap) seen = 1'b1;
    end
    tick();
    total++;
    if (seen !== 1'b1 || in_handler !== 1'b1 || trap_cause !== 32'h8000_0003) begin
      bad++; $display("FAIL abort_retake seen=%b inh=%b cause=%h want 1/1/80000003",
                      seen, in_handler, trap_cause);
    end
    reset = 1'b0;
    tick();
    total++;
    if (in_handler !== 1'b0 || trap_cause !== 32'd0 || trap_epc !== 32'd0 || flush_trap !== 1'b0
        || enable_out !== 8'h00 || pending_out !== 8'h00) begin
      bad++; $display("FAIL abort_reset_handler inh=%b cause=%h epc=%h flush=%b en=%h pend=%h want all 0",
                      in_handler, trap_cause, trap_epc, flush_trap, enable_out, pending_out);
    end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_level_irq();
    test_priority();
    test_edge();
    test_nesting();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
